// File: rtl/microseq_ctrl_stack_if.sv
// Bus bundle between the microsequencer and its environment: IR/PSR inputs,
// the control-store ROM handshake, and the registered sequencer outputs.
// The environment (master) drives ir/psr/stall and returns cs_data for the
// cs_addr the sequencer (slave) presents.
interface microseq_ctrl_stack_if #(
  parameter int CS_AW = 11,
  parameter int MIR_W = 41,
  parameter int PSR_W = 4,
  parameter int SC_W  = 3
);
  logic              stall;
  logic [31:0]       ir;
  logic [PSR_W-1:0]  psr;
  logic [MIR_W-1:0]  cs_data;
  logic [CS_AW-1:0]  cs_addr;
  logic [MIR_W-1:0]  mir;
  logic [CS_AW-1:0]  upc;
  logic [SC_W-1:0]   stack_cnt;
  logic [1:0]        stack_err;

  modport master (
    output stall, ir, psr, cs_data,
    input  cs_addr, mir, upc, stack_cnt, stack_err
  );

  modport slave (
    input  stall, ir, psr, cs_data,
    output cs_addr, mir, upc, stack_cnt, stack_err
  );
endinterface

// File: rtl/microseq_ctrl_stack.sv
// Microsequencer for the ARC datapath: selects the next control-store
// address from the current MIR condition field, registers the returned
// microinstruction, and keeps a small hardware return stack for CALL/RET.
//
// phase    | meaning
// ---------+-------------------------------------------------------------
// PH_BOOT  | after reset; cs_addr forced to 0 until the first live edge
// PH_RUN   | normal sequencing from the MIR condition field
module microseq_ctrl_stack #(
  parameter int CS_AW       = 11,
  parameter int MIR_W       = 41,
  parameter int STACK_DEPTH = 4,
  parameter int PSR_W       = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  microseq_ctrl_stack_if.slave  bus
);

  localparam int SC_W = $clog2(STACK_DEPTH + 1);
  // Entry index width; a depth-1 stack still needs a one-bit index.
  localparam int IX_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

  typedef enum logic [3:0] {
    C_NEXT  = 4'd0,
    C_BN    = 4'd1,
    C_BZ    = 4'd2,
    C_BV    = 4'd3,
    C_BC    = 4'd4,
    C_BIR13 = 4'd5,
    C_JMP   = 4'd6,
    C_DEC   = 4'd7,
    C_CALL  = 4'd8,
    C_RET   = 4'd9
  } cond_e;

  typedef enum logic {
    PH_BOOT = 1'b0,
    PH_RUN  = 1'b1
  } phase_e;

  phase_e            phase_q;
  logic [MIR_W-1:0]  mir_q;
  logic [CS_AW-1:0]  upc_q;
  logic [SC_W-1:0]   cnt_q;
  logic [1:0]        err_q;
  logic [CS_AW-1:0]  stack_mem [STACK_DEPTH];

  logic [CS_AW-1:0]  jaddr;
  cond_e             cond;
  logic [CS_AW-1:0]  inc;
  logic [CS_AW-1:0]  dec_addr;
  logic [CS_AW-1:0]  tos;
  logic [SC_W-1:0]   top_ptr;
  logic              stack_full;
  logic              stack_empty;

  logic [CS_AW-1:0]  next_addr;
  logic              do_push;
  logic              do_pop;
  logic              set_ovf;
  logic              set_unf;

  // Only a handful of IR bits steer sequencing; the rest belong to the datapath.
  logic unused_ir;
  assign unused_ir = ^{bus.ir[29:25], bus.ir[18:14], bus.ir[12:0]};

  assign jaddr       = mir_q[CS_AW-1:0];
  assign cond        = cond_e'(mir_q[CS_AW+3:CS_AW]);
  assign inc         = upc_q + {{(CS_AW-1){1'b0}}, 1'b1};
  assign dec_addr    = {1'b1, bus.ir[31:30], bus.ir[24:19], {(CS_AW-9){1'b0}}};
  assign stack_full  = (cnt_q == SC_W'(STACK_DEPTH));
  assign stack_empty = (cnt_q == '0);
  assign top_ptr     = cnt_q - {{(SC_W-1){1'b0}}, 1'b1};
  assign tos         = stack_mem[top_ptr[IX_W-1:0]];

  // Next-address select and stack intent from the current condition field.
  always_comb begin
    next_addr = inc;
    do_push   = 1'b0;
    do_pop    = 1'b0;
    set_ovf   = 1'b0;
    set_unf   = 1'b0;
    if (phase_q == PH_BOOT) begin
      next_addr = '0;
    end else begin
      case (cond)
        C_NEXT:  next_addr = inc;
        C_BN:    next_addr = bus.psr[3] ? jaddr : inc;
        C_BZ:    next_addr = bus.psr[2] ? jaddr : inc;
        C_BV:    next_addr = bus.psr[1] ? jaddr : inc;
        C_BC:    next_addr = bus.psr[0] ? jaddr : inc;
        C_BIR13: next_addr = bus.ir[13] ? jaddr : inc;
        C_JMP:   next_addr = jaddr;
        C_DEC:   next_addr = dec_addr;
        C_CALL: begin
          // The jump is taken even when the return address cannot be saved.
          next_addr = jaddr;
          if (stack_full) set_ovf = 1'b1;
          else            do_push = 1'b1;
        end
        C_RET: begin
          if (stack_empty) begin
            next_addr = '0;
            set_unf   = 1'b1;
          end else begin
            next_addr = tos;
            do_pop    = 1'b1;
          end
        end
        default: next_addr = inc;
      endcase
    end
  end

  // Sequencer state: phase, MIR, uPC, stack depth and sticky errors.
  always_ff @(posedge clk) begin
    if (rst) begin
      phase_q <= PH_BOOT;
      mir_q   <= '0;
      upc_q   <= '0;
      cnt_q   <= '0;
      err_q   <= '0;
    end else if (!bus.stall) begin
      phase_q <= PH_RUN;
      mir_q   <= bus.cs_data;
      upc_q   <= next_addr;
      if (do_push)     cnt_q <= cnt_q + {{(SC_W-1){1'b0}}, 1'b1};
      else if (do_pop) cnt_q <= top_ptr;
      err_q   <= err_q | {set_ovf, set_unf};
    end
  end

  // Return-address storage; contents above the depth count are don't-care.
  always_ff @(posedge clk) begin
    if (!rst && !bus.stall && do_push) begin
      stack_mem[cnt_q[IX_W-1:0]] <= inc;
    end
  end

  assign bus.cs_addr   = next_addr;
  assign bus.mir       = mir_q;
  assign bus.upc       = upc_q;
  assign bus.stack_cnt = cnt_q;
  assign bus.stack_err = err_q;

endmodule

// File: tb/tb_microseq_ctrl_stack.sv
module tb_microseq_ctrl_stack;

  logic clk;
  logic rst;
  int   errors;
  int   checks;

  logic [40:0] rom [2048];

  microseq_ctrl_stack_if #(.CS_AW(11), .MIR_W(41), .PSR_W(4), .SC_W(3)) bus ();

  microseq_ctrl_stack #(.CS_AW(11), .MIR_W(41), .STACK_DEPTH(4), .PSR_W(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  assign bus.cs_data = rom[bus.cs_addr];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  logic [40:0] m_mir;
  logic [10:0] m_upc;
  int          m_stk[$];
  logic [1:0]  m_err;
  bit          m_boot;

  function automatic logic [40:0] mk(input int c, input int j);
    logic [40:0] w;
    w = '0;
    w[14:11] = 4'(c);
    w[10:0]  = 11'(j);
    return w;
  endfunction

  function automatic int m_inc();
    return (int'(m_upc) + 1) % 2048;
  endfunction

  function automatic logic [10:0] model_next();
    int c, j;
    c = int'(m_mir[14:11]);
    j = int'(m_mir[10:0]);
    if (m_boot) return 11'd0;
    case (c)
      1: return 11'(bus.psr[3] ? j : m_inc());
      2: return 11'(bus.psr[2] ? j : m_inc());
      3: return 11'(bus.psr[1] ? j : m_inc());
      4: return 11'(bus.psr[0] ? j : m_inc());
      5: return 11'(bus.ir[13] ? j : m_inc());
      6: return 11'(j);
      7: return 11'(1024 + int'(bus.ir[31:30]) * 256 + int'(bus.ir[24:19]) * 4);
      8: return 11'(j);
      9: return (m_stk.size() == 0) ? 11'd0 : 11'(m_stk[$]);
      default: return 11'(m_inc());
    endcase
  endfunction

  task automatic model_clock();
    logic [10:0] a;
    int c;
    if (rst) begin
      m_mir = '0; m_upc = '0; m_stk.delete(); m_err = '0; m_boot = 1;
    end else if (!bus.stall) begin
      a = model_next();
      c = int'(m_mir[14:11]);
      if (!m_boot && c == 8) begin
        if (m_stk.size() == 4) m_err[1] = 1'b1;
        else m_stk.push_back(m_inc());
      end
      if (!m_boot && c == 9) begin
        if (m_stk.size() == 0) m_err[0] = 1'b1;
        else void'(m_stk.pop_back());
      end
      m_mir  = rom[a];
      m_upc  = a;
      m_boot = 0;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_clock();
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic clear_rom();
    for (int i = 0; i < 2048; i++) rom[i] = '0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    clear_rom();
    bus.stall = 1'b0; bus.ir = '0; bus.psr = '0;
    do_reset();
    checks++; if (bus.mir !== 41'd0) begin errors++; $display("FAIL reset_mir got=%h exp=0", bus.mir); end
    checks++; if (bus.upc !== 11'd0) begin errors++; $display("FAIL reset_upc got=%h exp=0", bus.upc); end
    checks++; if (bus.stack_cnt !== 3'd0) begin errors++; $display("FAIL reset_cnt got=%0d exp=0", bus.stack_cnt); end
    checks++; if (bus.stack_err !== 2'b00) begin errors++; $display("FAIL reset_err got=%b exp=00", bus.stack_err); end
    checks++; if (bus.cs_addr !== 11'd0) begin errors++; $display("FAIL reset_boot_addr got=%h exp=0", bus.cs_addr); end
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++; if (bus.upc !== 11'(i)) begin errors++; $display("FAIL reset_seq_upc got=%h exp=%h", bus.upc, 11'(i)); end
    end
    checks++; if (bus.stack_err !== 2'b00) begin errors++; $display("FAIL reset_seq_err got=%b exp=00", bus.stack_err); end
  endtask

  task automatic test_call_ret();
    clear_rom();
    rom[5]     = mk(8, 'h100);
    rom['h100] = mk(9, 0);
    do_reset();
    repeat (6) tick();
    checks++; if (bus.upc !== 11'd5 || bus.stack_cnt !== 3'd0) begin errors++; $display("FAIL call_pre got upc=%h cnt=%0d exp upc=005 cnt=0", bus.upc, bus.stack_cnt); end
    tick();
    checks++; if (bus.upc !== 11'h100 || bus.stack_cnt !== 3'd1) begin errors++; $display("FAIL call_jump got upc=%h cnt=%0d exp upc=100 cnt=1", bus.upc, bus.stack_cnt); end
    tick();
    checks++; if (bus.upc !== 11'd6 || bus.stack_cnt !== 3'd0) begin errors++; $display("FAIL ret_return got upc=%h cnt=%0d exp upc=006 cnt=0", bus.upc, bus.stack_cnt); end
  endtask

  task automatic test_decode();
    logic [31:0] irv;
    clear_rom();
    rom[1] = mk(7, 'h055);
    irv = 32'h0000_1555;
    irv[31:30] = 2'b10;
    irv[24:19] = 6'h3A;
    bus.ir = irv;
    do_reset();
    tick(); tick();
    #1;
    checks++; if (bus.cs_addr !== 11'h6E8) begin errors++; $display("FAIL decode_addr got=%h exp=6e8", bus.cs_addr); end
    tick();
    checks++; if (bus.upc !== 11'h6E8) begin errors++; $display("FAIL decode_upc got=%h exp=6e8", bus.upc); end
    bus.ir = '0;
  endtask

  task automatic test_overflow();
    clear_rom();
    rom[1]    = mk(8, 'h10);
    rom['h10] = mk(8, 'h20);
    rom['h20] = mk(8, 'h30);
    rom['h30] = mk(8, 'h40);
    rom['h40] = mk(8, 'h50);
    do_reset();
    tick(); tick();
    repeat (4) tick();
    checks++; if (bus.stack_cnt !== 3'd4 || bus.stack_err !== 2'b00) begin errors++; $display("FAIL ovf_full got cnt=%0d err=%b exp cnt=4 err=00", bus.stack_cnt, bus.stack_err); end
    tick();
    checks++; if (bus.upc !== 11'h50) begin errors++; $display("FAIL ovf_jump got=%h exp=050", bus.upc); end
    checks++; if (bus.stack_cnt !== 3'd4) begin errors++; $display("FAIL ovf_cnt got=%0d exp=4", bus.stack_cnt); end
    checks++; if (bus.stack_err !== 2'b10) begin errors++; $display("FAIL ovf_err got=%b exp=10", bus.stack_err); end
  endtask

  task automatic test_underflow_branch();
    clear_rom();
    rom[1] = mk(9, 'h3C3);
    do_reset();
    tick(); tick();
    #1;
    checks++; if (bus.cs_addr !== 11'd0) begin errors++; $display("FAIL unf_addr got=%h exp=000", bus.cs_addr); end
    tick();
    checks++; if (bus.stack_err !== 2'b01 || bus.stack_cnt !== 3'd0 || bus.upc !== 11'd0) begin errors++; $display("FAIL unf_state got err=%b cnt=%0d upc=%h exp err=01 cnt=0 upc=000", bus.stack_err, bus.stack_cnt, bus.upc); end
    clear_rom();
    rom[1] = mk(2, 'h123);
    do_reset();
    tick(); tick();
    bus.psr = 4'b0100; #1;
    checks++; if (bus.cs_addr !== 11'h123) begin errors++; $display("FAIL bz_taken got=%h exp=123", bus.cs_addr); end
    bus.psr = 4'b0000; #1;
    checks++; if (bus.cs_addr !== 11'h002) begin errors++; $display("FAIL bz_not_taken got=%h exp=002", bus.cs_addr); end
    bus.psr = 4'b1011; #1;
    checks++; if (bus.cs_addr !== 11'h002) begin errors++; $display("FAIL bz_other_flags got=%h exp=002", bus.cs_addr); end
    bus.psr = '0;
  endtask

  task automatic test_stall();
    clear_rom();
    rom[1] = mk(8, 'h200);
    do_reset();
    tick(); tick();
    bus.stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (bus.upc !== 11'd1 || bus.mir !== mk(8, 'h200) || bus.stack_cnt !== 3'd0) begin errors++; $display("FAIL stall_hold got upc=%h mir=%h cnt=%0d exp upc=001 cnt=0", bus.upc, bus.mir, bus.stack_cnt); end
      checks++; if (bus.cs_addr !== 11'h200) begin errors++; $display("FAIL stall_addr got=%h exp=200", bus.cs_addr); end
    end
    bus.stall = 1'b0;
    tick();
    checks++; if (bus.upc !== 11'h200 || bus.stack_cnt !== 3'd1) begin errors++; $display("FAIL stall_release got upc=%h cnt=%0d exp upc=200 cnt=1", bus.upc, bus.stack_cnt); end
    tick();
    checks++; if (bus.upc !== 11'h201 || bus.stack_cnt !== 3'd1) begin errors++; $display("FAIL stall_single_push got upc=%h cnt=%0d exp upc=201 cnt=1", bus.upc, bus.stack_cnt); end
    // uPC wrap from all-ones
    clear_rom();
    rom[1] = mk(6, 'h7FF);
    do_reset();
    tick(); tick(); tick();
    checks++; if (bus.upc !== 11'h7FF || bus.cs_addr !== 11'h000) begin errors++; $display("FAIL wrap_addr got upc=%h cs_addr=%h exp upc=7ff cs_addr=000", bus.upc, bus.cs_addr); end
    tick();
    checks++; if (bus.upc !== 11'h000) begin errors++; $display("FAIL wrap_upc got=%h exp=000", bus.upc); end
    // reset overrides a stalled, pending CALL
    clear_rom();
    rom[1] = mk(8, 'h200);
    do_reset();
    tick(); tick();
    bus.stall = 1'b1;
    tick();
    rst = 1'b1;
    tick();
    checks++; if (bus.upc !== 11'd0 || bus.mir !== 41'd0 || bus.stack_cnt !== 3'd0 || bus.stack_err !== 2'b00) begin errors++; $display("FAIL reset_midop got upc=%h mir=%h cnt=%0d err=%b exp all zero", bus.upc, bus.mir, bus.stack_cnt, bus.stack_err); end
    rst = 1'b0;
    bus.stall = 1'b0;
  endtask

  task automatic test_random();
    logic [40:0] w;
    logic [10:0] ea;
    int nbad;
    for (int i = 0; i < 2048; i++) begin
      w[31:0]  = $urandom;
      w[40:32] = 9'($urandom);
      w[14:11] = 4'($urandom_range(0, 15));
      rom[i] = w;
    end
    do_reset();
    nbad = 0;
    for (int n = 0; n < 600; n++) begin
      bus.stall = ($urandom_range(0, 3) == 0);
      bus.psr   = 4'($urandom);
      bus.ir    = $urandom;
      rst       = ($urandom_range(0, 99) == 0);
      #1;
      ea = model_next();
      checks++; if (bus.cs_addr !== ea) begin errors++; nbad++; if (nbad < 10) $display("FAIL rand_cs_addr n=%0d got=%h exp=%h", n, bus.cs_addr, ea); end
      tick();
      checks++; if (bus.upc !== m_upc || bus.mir !== m_mir) begin errors++; nbad++; if (nbad < 10) $display("FAIL rand_upc_mir n=%0d got upc=%h mir=%h exp upc=%h mir=%h", n, bus.upc, bus.mir, m_upc, m_mir); end
      checks++; if (bus.stack_cnt !== 3'(m_stk.size()) || bus.stack_err !== m_err) begin errors++; nbad++; if (nbad < 10) $display("FAIL rand_stack n=%0d got cnt=%0d err=%b exp cnt=%0d err=%b", n, bus.stack_cnt, bus.stack_err, m_stk.size(), m_err); end
    end
    rst = 1'b0;
    bus.stall = 1'b0;
  endtask

  initial begin
    errors = 0;
    checks = 0;
    rst = 1'b1;
    bus.stall = 1'b0;
    bus.ir = '0;
    bus.psr = '0;
    m_mir = '0; m_upc = '0; m_err = '0; m_boot = 1;
    clear_rom();
    #2;
    test_reset();
    test_call_ret();
    test_decode();
    test_overflow();
    test_underflow_branch();
    test_stall();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog_timeout got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
